rom_saver: RTL

//  Upload path from core to ZPUFlex host; the reverse of the host->core boot-data loader.

---
 rtl/rom_saver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rom_saver.sv
// rom_saver: uploads core memory to the ZPUFlex host.
// Bytes are read over the ioctl bus and packed big-endian into 32-bit words. The first byte
// of each word goes to [31:24]. Each word is then handed over with a 4-phase req/ack handshake.
//
// Ports
//   clk, reset_n        system clock, synchronous active-low reset
//   host_upload         level; its rising edge starts an upload, dropping it aborts
//   host_upload_size    byte count minus one, latched at start
//   host_file_type      selects ioctl_index (rom / .o / .c / .p)
//   host_updata         packed word presented to the host
//   host_updata_req     word valid / request
//   host_updata_ack     host acknowledge
//   upload_done         set once every byte has been delivered; cleared by the next start
//   ioctl_upload        copy of host_upload
//   ioctl_index         file index derived from host_file_type
//   ioctl_rd            one-clock byte read strobe
//   ioctl_addr          byte address of the current read
//   ioctl_din           byte read data, valid RD_LATENCY clocks after ioctl_rd
module rom_saver #(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_upload,
  input  logic [15:0] host_upload_size,
  input  logic [2:0]  host_file_type,
  output logic [31:0] host_updata,
  output logic        host_updata_req,
  input  logic        host_updata_ack,
  output logic        upload_done,
  output logic        ioctl_upload,
  output logic [15:0] ioctl_index,
  output logic        ioctl_rd,
  output logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_din
);

  typedef enum logic [2:0] {StIdle, StRd, StWait, StSend, StAckLo} state_e;

  state_e      state_q, state_d;
  logic        upload_pre_q;
  logic [16:0] addr_q;
  logic [16:0] count_q;
  logic [16:0] total_q;
  logic [1:0]  idx_q;
  logic [2:0]  wait_cnt_q;
  logic [31:0] word_q, word_next;
  logic        req_q, rd_q, done_q;

  logic        start;
  logic        last_wait;
  logic        capture;
  logic [16:0] count_inc;

  assign start     = host_upload & ~upload_pre_q;
  assign last_wait = (wait_cnt_q == 3'(RD_LATENCY - 1));
  assign count_inc = count_q + 17'd1;
  assign capture   = (state_q == StWait) && last_wait && host_upload && !start;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic. Start overrides everything, then abort, then normal flow.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = state_q;
      StRd:    state_d = StWait;
      StWait: begin
        if (last_wait) begin
          state_d = (idx_q == 2'd3 || count_inc == total_q) ? StSend : StRd;
        end
      end
      StSend:  if (req_q && host_updata_ack) state_d = StAckLo;
      StAckLo: if (!host_updata_ack) state_d = (count_q == total_q) ? StIdle : StRd;
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle && !host_upload) state_d = StIdle;
    if (start) state_d = StRd;
  end

  // Edge detector runs through reset so a level still high after reset is not a new start.
  always_ff @(posedge clk) begin
    upload_pre_q <= host_upload;
  end

  // Byte lane insertion; lane 0 starts a fresh word so unfilled lanes read as zero.
  always_comb begin
    word_next = (idx_q == 2'd0) ? 32'h0 : word_q;
    unique case (idx_q)
      2'd0: word_next[31:24] = ioctl_din;
      2'd1: word_next[23:16] = ioctl_din;
      2'd2: word_next[15:8]  = ioctl_din;
      2'd3: word_next[7:0]   = ioctl_din;
      default: word_next = word_q;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q     <= '0;
      count_q    <= '0;
      total_q    <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      word_q     <= '0;
      req_q      <= 1'b0;
      rd_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_q       <= (state_d == StRd);
      // A request is raised only while ack is low, so a stale ack is never taken.
      req_q      <= (state_d == StSend) && (req_q || !host_updata_ack);
      wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + 3'd1 : 3'd0;
      if (start) begin
        addr_q  <= '0;
        count_q <= '0;
        idx_q   <= '0;
        done_q  <= 1'b0;
        total_q <= {1'b0, host_upload_size} + 17'd1;
      end else begin
        if (capture) begin
          addr_q  <= addr_q + 17'd1;
          count_q <= count_inc;
          word_q  <= word_next;
          if (state_d == StRd) idx_q <= idx_q + 2'd1;
        end
        if (state_q == StAckLo && state_d == StRd) idx_q <= 2'd0;
        if (state_q == StAckLo && state_d == StIdle && host_upload) done_q <= 1'b1;
      end
    end
  end

  // Outputs.
  always_comb begin
    host_updata     = word_q;
    host_updata_req = req_q;
    upload_done     = done_q;
    ioctl_rd        = rd_q;
    ioctl_addr      = {10'd0, addr_q};
    ioctl_upload    = host_upload;
    unique case (host_file_type)
      3'b111:  ioctl_index = 16'h0000;
      3'b010:  ioctl_index = 16'h001F;
      3'b011:  ioctl_index = 16'h003F;
      default: ioctl_index = 16'h005F;
    endcase
  end

endmodule
